square_motion_engine: RTL and testbench



---
 rtl/square_motion_pkg.sv | 39 +++
 rtl/bounce_axis_step.sv | 39 +++
 rtl/square_motion_engine.sv | 131 +++++++++++++
 tb/tb_square_motion_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/square_motion_pkg.sv
// rtl/square_motion_pkg.sv - FSM states, reset tables and per-object speeds for square_motion_engine
package square_motion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPD_X,
    UPD_Y,
    COMMIT
  } state_t;

  localparam int MAX_OBJ = 8;

  // Entry i is object i; the first four match the demo's opening layout.
  localparam logic [9:0] X_INIT [MAX_OBJ] = '{10'd0, 10'd120, 10'd100, 10'd40,
                                              10'd200, 10'd300, 10'd400, 10'd500};
  localparam logic [9:0] Y_INIT [MAX_OBJ] = '{10'd300, 10'd300, 10'd400, 10'd200,
                                              10'd100, 10'd150, 10'd250, 10'd350};

  // Bit i is object i's direction, 1 = moving positive.
  localparam logic [MAX_OBJ-1:0] DIRX_INIT = 8'b0101_1110;
  localparam logic [MAX_OBJ-1:0] DIRY_INIT = 8'b1010_1101;

  function automatic logic [7:0] speed_x_pos(input logic [3:0] idx);
    return 8'd7 + {4'd0, idx};
  endfunction

  function automatic logic [7:0] speed_x_neg(input logic [3:0] idx);
    return 8'd3 + {4'd0, idx};
  endfunction

  function automatic logic [7:0] speed_y_pos(input logic [3:0] idx);
    return 8'd6 + {4'd0, idx};
  endfunction

  function automatic logic [7:0] speed_y_neg(input logic [3:0] idx);
    return 8'd10 + {4'd0, idx};
  endfunction

endpackage

// File: rtl/bounce_axis_step.sv
// rtl/bounce_axis_step.sv - one-axis position advance with edge bounce (combinational)
module bounce_axis_step #(
  parameter int POS_W = 10
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  input  logic [POS_W-1:0] speed_pos,
  input  logic [POS_W-1:0] speed_neg,
  input  logic [POS_W-1:0] hi,
  output logic [POS_W-1:0] next_pos,
  output logic             next_dir
);

  // One spare bit keeps pos+speed from wrapping before the compare.
  logic [POS_W:0] sum;

  assign sum = {1'b0, pos} + {1'b0, speed_pos};

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (dir) begin
      if (sum >= {1'b0, hi}) begin
        next_pos = hi;
        next_dir = 1'b0;
      end else begin
        next_pos = sum[POS_W-1:0];
      end
    end else begin
      if (pos <= speed_neg) begin
        next_pos = '0;
        next_dir = 1'b1;
      end else begin
        next_pos = pos - speed_neg;
      end
    end
  end

endmodule

// File: rtl/square_motion_engine.sv
// rtl/square_motion_engine.sv - per-frame square motion with shadowed commit; MOTION_PAUSE_EN adds pause
module square_motion_engine
  import square_motion_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int X_LIMIT = 640,
  parameter int Y_LIMIT = 480,
  parameter int POS_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
`ifdef MOTION_PAUSE_EN
  input  logic                     pause,
`endif
  input  logic [8:0]               obj_size,
  output logic [NUM_OBJ*POS_W-1:0] obj_x,
  output logic [NUM_OBJ*POS_W-1:0] obj_y,
  output logic                     busy,
  output logic                     update_done
);

  localparam int KW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [POS_W:0] LIM_X = (POS_W+1)'(X_LIMIT);
  localparam logic [POS_W:0] LIM_Y = (POS_W+1)'(Y_LIMIT);

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [8:0]       size_q;
  logic [POS_W-1:0] sx [NUM_OBJ];
  logic [POS_W-1:0] sy [NUM_OBJ];
  logic [NUM_OBJ-1:0] dx, dy;

  logic             tick_ok, last_obj, on_y;
  logic [POS_W:0]   size_w;
  logic [POS_W-1:0] hi_x, hi_y;
  logic [POS_W-1:0] cur_pos, cur_spd_p, cur_spd_n, cur_hi, nxt_pos;
  logic             cur_dir, nxt_dir;

`ifdef MOTION_PAUSE_EN
  assign tick_ok = frame_tick & ~pause;
`else
  assign tick_ok = frame_tick;
`endif

  assign last_obj = (k == KW'(NUM_OBJ - 1));
  assign busy     = (state != IDLE);
  assign on_y     = (state == UPD_Y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick_ok) state_nxt = UPD_X;
      UPD_X:   state_nxt = UPD_Y;
      UPD_Y:   state_nxt = last_obj ? COMMIT : UPD_X;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Upper bound saturates to 0 once the square is as large as the screen.
  assign size_w = (POS_W+1)'(size_q);
  assign hi_x   = (size_w >= LIM_X) ? '0 : POS_W'(LIM_X - size_w);
  assign hi_y   = (size_w >= LIM_Y) ? '0 : POS_W'(LIM_Y - size_w);

  assign cur_pos   = on_y ? sy[k] : sx[k];
  assign cur_dir   = on_y ? dy[k] : dx[k];
  assign cur_hi    = on_y ? hi_y  : hi_x;
  assign cur_spd_p = on_y ? POS_W'(speed_y_pos(4'(k))) : POS_W'(speed_x_pos(4'(k)));
  assign cur_spd_n = on_y ? POS_W'(speed_y_neg(4'(k))) : POS_W'(speed_x_neg(4'(k)));

  bounce_axis_step #(.POS_W(POS_W)) u_step (
    .pos       (cur_pos),
    .dir       (cur_dir),
    .speed_pos (cur_spd_p),
    .speed_neg (cur_spd_n),
    .hi        (cur_hi),
    .next_pos  (nxt_pos),
    .next_dir  (nxt_dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k           <= '0;
      size_q      <= '0;
      update_done <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        sx[i]                  <= POS_W'(X_INIT[i]);
        sy[i]                  <= POS_W'(Y_INIT[i]);
        dx[i]                  <= DIRX_INIT[i];
        dy[i]                  <= DIRY_INIT[i];
        obj_x[i*POS_W +: POS_W] <= POS_W'(X_INIT[i]);
        obj_y[i*POS_W +: POS_W] <= POS_W'(Y_INIT[i]);
      end
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_ok) begin
            size_q <= obj_size;
            k      <= '0;
          end
        end
        UPD_X: begin
          sx[k] <= nxt_pos;
          dx[k] <= nxt_dir;
        end
        UPD_Y: begin
          sy[k] <= nxt_pos;
          dy[k] <= nxt_dir;
          if (!last_obj) k <= k + KW'(1);
        end
        COMMIT: begin
          // The renderer only ever sees a full set, swapped in one edge.
          for (int i = 0; i < NUM_OBJ; i++) begin
            obj_x[i*POS_W +: POS_W] <= sx[i];
            obj_y[i*POS_W +: POS_W] <= sy[i];
          end
          update_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_motion_engine.sv
// tb/tb_square_motion_engine.sv - self-checking bench for square_motion_engine (MOTION_PAUSE_EN optional)
module tb_square_motion_engine;

  localparam int N  = 4;
  localparam int PW = 10;
  localparam int LAT = 2 * N + 2;

  logic          clk;
  logic          reset;
  logic          frame_tick;
  logic [8:0]    obj_size;
  logic [N*PW-1:0] obj_x, obj_y;
  logic          busy, update_done;
`ifdef MOTION_PAUSE_EN
  logic          pause;
`endif

  int n_cmp;
  int n_err;

  int mx [N];
  int my [N];
  bit mdx [N];
  bit mdy [N];

  square_motion_engine #(.NUM_OBJ(N), .X_LIMIT(640), .Y_LIMIT(480), .POS_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
`ifdef MOTION_PAUSE_EN
    .pause       (pause),
`endif
    .obj_size    (obj_size),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .busy        (busy),
    .update_done (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*PW-1:0] pk(input int a [N]);
    logic [N*PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(a[i]);
    return r;
  endfunction

  task automatic model_reset();
    mx  = '{0, 120, 100, 40};
    my  = '{300, 300, 400, 200};
    mdx = '{0, 1, 1, 1};
    mdy = '{1, 0, 1, 1};
  endtask

  function automatic void move(inout int p, inout bit d, input int sp, input int sn, input int hi);
    if (d) begin
      if (p + sp >= hi) begin p = hi; d = 0; end
      else p = p + sp;
    end else begin
      if (p <= sn) begin p = 0; d = 1; end
      else p = p - sn;
    end
  endfunction

  function automatic void step_model(input int size);
    int hx, hy;
    hx = (size >= 640) ? 0 : 640 - size;
    hy = (size >= 480) ? 0 : 480 - size;
    for (int i = 0; i < N; i++) begin
      move(mx[i], mdx[i], 7 + i, 3 + i, hx);
      move(my[i], mdy[i], 6 + i, 10 + i, hy);
    end
  endfunction

  // Called at the negedge of cycle T+1 after a tick was accepted at T.
  // Leaves the bench at the negedge after the commit cycle.
  task automatic follow(input string tag, input int size, input bit chain, input int chain_size);
    logic [N*PW-1:0] old_x, old_y;
    old_x = pk(mx);
    old_y = pk(my);
    for (int n = 1; n <= LAT; n++) begin
      if (n < LAT) begin
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " no_done"}, update_done, 1'b0);
        check({tag, " x_hold"}, obj_x, old_x);
        check({tag, " y_hold"}, obj_y, old_y);
        @(negedge clk);
      end else begin
        step_model(size);
        check({tag, " done"}, update_done, 1'b1);
        check({tag, " busy_low"}, busy, 1'b0);
        check({tag, " obj_x"}, obj_x, pk(mx));
        check({tag, " obj_y"}, obj_y, pk(my));
      end
    end
    if (chain) begin
      frame_tick = 1'b1;
      obj_size   = 9'(chain_size);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, " done_pulse"}, update_done, 1'b0);
  endtask

  task automatic do_frame(input string tag, input int size);
    @(negedge clk);
    frame_tick = 1'b1;
    obj_size   = 9'(size);
    @(negedge clk);
    frame_tick = 1'b0;
    follow(tag, size, 1'b0, 0);
  endtask

  initial begin
    int pulses;
    int sz, sz2;
    n_cmp = 0;
    n_err = 0;
    reset      = 1'b1;
    frame_tick = 1'b0;
    obj_size   = 9'd0;
`ifdef MOTION_PAUSE_EN
    pause      = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst obj_x", obj_x, {10'd40, 10'd100, 10'd120, 10'd0});
    check("rst obj_y", obj_y, {10'd200, 10'd400, 10'd300, 10'd300});
    check("rst busy", busy, 1'b0);
    check("rst done", update_done, 1'b0);

    do_frame("f1", 80);
    check("f1 x0", obj_x[9:0], 10'd0);
    check("f1 y0", obj_y[9:0], 10'd306);
    check("f1 x1", obj_x[19:10], 10'd128);
    check("f1 y1", obj_y[19:10], 10'd289);
    check("f1 y2_clamp", obj_y[29:20], 10'd400);

    do_frame("f2", 80);
    check("f2 y2_back", obj_y[29:20], 10'd388);

    // Ticks during busy; the one at T+9 lands on the commit cycle.
    sz = 100;
    pulses = 0;
    @(negedge clk);
    for (int c = 0; c < 25; c++) begin
      frame_tick = (c == 0 || c == 3 || c == 6 || c == 9);
      obj_size   = (c == 0) ? 9'(sz) : 9'($urandom_range(0, 511));
      @(negedge clk);
      if (update_done) pulses++;
    end
    frame_tick = 1'b0;
    step_model(sz);
    check("busy_ign pulses", pulses, 1);
    check("busy_ign obj_x", obj_x, pk(mx));
    check("busy_ign obj_y", obj_y, pk(my));

    // Tick in the very cycle busy falls must start a new sequence.
    @(negedge clk);
    frame_tick = 1'b1;
    obj_size   = 9'd60;
    @(negedge clk);
    frame_tick = 1'b0;
    follow("chain_a", 60, 1'b1, 200);
    follow("chain_b", 200, 1'b0, 0);

    // Screen-sized square: Y bound saturates to 0.
    do_frame("sat", 490);
    do_frame("after_sat", 20);

    for (int r = 0; r < 10; r++) begin
      sz = $urandom_range(0, 511);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_frame("rnd", sz);
    end

    // Reset in the middle of a sequence.
    @(negedge clk);
    frame_tick = 1'b1;
    obj_size   = 9'd40;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("midrst obj_x", obj_x, pk(mx));
    check("midrst obj_y", obj_y, pk(my));
    check("midrst busy", busy, 1'b0);
    check("midrst done", update_done, 1'b0);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (update_done) pulses++;
    end
    check("midrst no_commit", pulses, 0);
    do_frame("post_rst", 80);
    check("post_rst y0", obj_y[9:0], 10'd306);

`ifdef MOTION_PAUSE_EN
    pause = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      frame_tick = (c == 1 || c == 5 || c == 9);
      obj_size   = 9'd50;
      if (update_done) pulses++;
    end
    frame_tick = 1'b0;
    @(negedge clk);
    check("pause pulses", pulses, 0);
    check("pause busy", busy, 1'b0);
    check("pause obj_x", obj_x, pk(mx));
    check("pause obj_y", obj_y, pk(my));
    pause = 1'b0;
    do_frame("unpause", 50);
`endif

    sz2 = n_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, sz2);
    $finish;
  end

endmodule
